// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - SECDED helper functions shared by the bus link
// Functions work on max-width vectors; callers zero-extend and truncate with casts.
package ecc_pkg;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_CW_W   = 128;
  localparam int SYN_W      = 8;

  typedef logic [MAX_DATA_W-1:0] data_max_t;
  typedef logic [MAX_CW_W-1:0]   cw_max_t;
  typedef logic [SYN_W-1:0]      syn_t;

  function automatic int calc_p_w(input int data_w);
    int p;
    p = 1;
    for (int i = 0; i < SYN_W; i++)
      if ((1 << p) < data_w + p + 1) p++;
    return p;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos & (pos - 1)) == 0;
  endfunction

  function automatic syn_t ecc_syndrome(input cw_max_t cw, input int cw_w);
    syn_t s;
    s = '0;
    for (int pos = 1; pos < MAX_CW_W; pos++)
      if (pos < cw_w && cw[pos]) s = s ^ SYN_W'(pos);
    return s;
  endfunction

  function automatic cw_max_t ecc_encode(input data_max_t data, input int cw_w);
    cw_max_t cw;
    syn_t    s;
    int      j;
    cw = '0;
    j  = 0;
    for (int pos = 1; pos < MAX_CW_W; pos++)
      if (pos < cw_w && !is_pow2(pos)) begin
        cw[pos] = data[j];
        j++;
      end
    // Parity bits are zero here, so the syndrome is exactly the parity to insert.
    s = ecc_syndrome(cw, cw_w);
    for (int pos = 1; pos < MAX_CW_W; pos++)
      if (pos < cw_w && is_pow2(pos)) cw[pos] = |(s & SYN_W'(pos));
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic cw_max_t ecc_correct(input cw_max_t cw, input syn_t s, input logic fix);
    cw_max_t c;
    c = cw;
    for (int i = 0; i < MAX_CW_W; i++)
      if (fix && i == int'(s)) c[i] = ~c[i];
    return c;
  endfunction

  function automatic data_max_t ecc_extract(input cw_max_t cw, input int cw_w);
    data_max_t d;
    int        j;
    d = '0;
    j = 0;
    for (int pos = 1; pos < MAX_CW_W; pos++)
      if (pos < cw_w && !is_pow2(pos)) begin
        d[j] = cw[pos];
        j++;
      end
    return d;
  endfunction

endpackage

// File: rtl/ecc_bus_link_stage.sv
// rtl/ecc_bus_link_stage.sv - one-deep elastic register (ecc_pipe_stage)
// Ready stays low until the first clock after reset release.
module ecc_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         live;
  logic         full;
  logic [W-1:0] q;

  assign in_ready  = live && (!full || out_ready);
  assign out_valid = full;
  assign out_data  = q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live <= 1'b0;
      full <= 1'b0;
      q    <= '0;
    end else begin
      live <= 1'b1;
      if (in_valid && in_ready) begin
        full <= 1'b1;
        q    <= in_data;
      end else if (out_ready) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ecc_bus_link.sv
// rtl/ecc_bus_link.sv - SECDED encode/decode link with injection and error counters
// Encode: 1 elastic stage. Decode: syndrome stage then correction stage.
module ecc_bus_link
  import ecc_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int CNT_W  = 16,
  localparam int P_W    = calc_p_w(DATA_W),
  localparam int CW_W   = DATA_W + P_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enc_in_valid,
  output logic              enc_in_ready,
  input  logic [DATA_W-1:0] enc_in_data,
  input  logic              inj_en,
  input  logic [CW_W-1:0]   inj_mask,
  output logic              enc_out_valid,
  input  logic              enc_out_ready,
  output logic [CW_W-1:0]   enc_out_cw,
  input  logic              dec_in_valid,
  output logic              dec_in_ready,
  input  logic [CW_W-1:0]   dec_in_cw,
  output logic              dec_out_valid,
  input  logic              dec_out_ready,
  output logic [DATA_W-1:0] dec_out_data,
  output logic              dec_out_sbe,
  output logic              dec_out_dbe,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sbe_count,
  output logic [CNT_W-1:0]  dbe_count
);

  localparam int S1_W = SYN_W + 1 + CW_W;
  localparam int S2_W = DATA_W + 2;

  logic [CW_W-1:0] enc_cw;

  always_comb begin
    enc_cw = CW_W'(ecc_encode(MAX_DATA_W'(enc_in_data), CW_W));
    if (inj_en) enc_cw = enc_cw ^ inj_mask;
  end

  ecc_pipe_stage #(.W(CW_W)) u_enc (
    .clk(clk), .reset_n(reset_n),
    .in_valid(enc_in_valid), .in_ready(enc_in_ready), .in_data(enc_cw),
    .out_valid(enc_out_valid), .out_ready(enc_out_ready), .out_data(enc_out_cw)
  );

  logic [S1_W-1:0] s1_in, s1_q;
  logic            s1_valid, s1_ready;
  logic [SYN_W-1:0] s1_s;
  logic            s1_o;
  logic [CW_W-1:0] s1_cw, s1_fixed;
  logic            fix_ok, dbe;
  logic [S2_W-1:0] s2_in, s2_q;

  assign s1_in = {ecc_syndrome(MAX_CW_W'(dec_in_cw), CW_W), ^dec_in_cw, dec_in_cw};

  ecc_pipe_stage #(.W(S1_W)) u_dec_s1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(dec_in_valid), .in_ready(dec_in_ready), .in_data(s1_in),
    .out_valid(s1_valid), .out_ready(s1_ready), .out_data(s1_q)
  );

  assign {s1_s, s1_o, s1_cw} = s1_q;
  // Odd overall parity with an in-range syndrome is a single flip (s=0 means cw[0]).
  assign fix_ok   = s1_o && (int'(s1_s) < CW_W);
  assign dbe      = s1_o ? !fix_ok : (s1_s != '0);
  assign s1_fixed = CW_W'(ecc_correct(MAX_CW_W'(s1_cw), s1_s, fix_ok));
  assign s2_in    = {fix_ok, dbe, DATA_W'(ecc_extract(MAX_CW_W'(s1_fixed), CW_W))};

  ecc_pipe_stage #(.W(S2_W)) u_dec_s2 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(s1_valid), .in_ready(s1_ready), .in_data(s2_in),
    .out_valid(dec_out_valid), .out_ready(dec_out_ready), .out_data(s2_q)
  );

  assign {dec_out_sbe, dec_out_dbe, dec_out_data} = s2_q;

  logic dec_hs;
  assign dec_hs = dec_out_valid && dec_out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sbe_count <= '0;
      dbe_count <= '0;
    end else if (cnt_clr) begin
      sbe_count <= '0;
      dbe_count <= '0;
    end else begin
      if (dec_hs && dec_out_sbe && !(&sbe_count)) sbe_count <= sbe_count + CNT_W'(1);
      if (dec_hs && dec_out_dbe && !(&dbe_count)) dbe_count <= dbe_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ecc_bus_link.sv
// tb/tb_ecc_bus_link.sv - loopback bench for ecc_bus_link with scoreboard model
module tb_ecc_bus_link;

  localparam int DW = 32;
  localparam int CW = 39;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          enc_in_valid, enc_in_ready, inj_en, cnt_clr, dec_out_ready;
  logic [DW-1:0] enc_in_data;
  logic [CW-1:0] inj_mask;
  logic          enc_out_valid, enc_out_ready, dec_in_valid, dec_in_ready;
  logic [CW-1:0] enc_out_cw, dec_in_cw;
  logic          dec_out_valid, dec_out_sbe, dec_out_dbe;
  logic [DW-1:0] dec_out_data;
  logic [15:0]   sbe_count, dbe_count;

  logic          enc_in_ready4, enc_out_valid4, enc_out_ready4, dec_in_valid4, dec_in_ready4;
  logic [CW-1:0] enc_out_cw4, dec_in_cw4;
  logic          dec_out_valid4, dec_out_sbe4, dec_out_dbe4;
  logic [DW-1:0] dec_out_data4;
  logic [3:0]    sbe_count4, dbe_count4;

  assign dec_in_valid   = enc_out_valid;
  assign dec_in_cw      = enc_out_cw;
  assign enc_out_ready  = dec_in_ready;
  assign dec_in_valid4  = enc_out_valid4;
  assign dec_in_cw4     = enc_out_cw4;
  assign enc_out_ready4 = dec_in_ready4;

  ecc_bus_link #(.DATA_W(DW), .CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .enc_in_valid(enc_in_valid), .enc_in_ready(enc_in_ready), .enc_in_data(enc_in_data),
    .inj_en(inj_en), .inj_mask(inj_mask),
    .enc_out_valid(enc_out_valid), .enc_out_ready(enc_out_ready), .enc_out_cw(enc_out_cw),
    .dec_in_valid(dec_in_valid), .dec_in_ready(dec_in_ready), .dec_in_cw(dec_in_cw),
    .dec_out_valid(dec_out_valid), .dec_out_ready(dec_out_ready), .dec_out_data(dec_out_data),
    .dec_out_sbe(dec_out_sbe), .dec_out_dbe(dec_out_dbe),
    .cnt_clr(cnt_clr), .sbe_count(sbe_count), .dbe_count(dbe_count)
  );

  ecc_bus_link #(.DATA_W(DW), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .enc_in_valid(enc_in_valid), .enc_in_ready(enc_in_ready4), .enc_in_data(enc_in_data),
    .inj_en(inj_en), .inj_mask(inj_mask),
    .enc_out_valid(enc_out_valid4), .enc_out_ready(enc_out_ready4), .enc_out_cw(enc_out_cw4),
    .dec_in_valid(dec_in_valid4), .dec_in_ready(dec_in_ready4), .dec_in_cw(dec_in_cw4),
    .dec_out_valid(dec_out_valid4), .dec_out_ready(dec_out_ready), .dec_out_data(dec_out_data4),
    .dec_out_sbe(dec_out_sbe4), .dec_out_dbe(dec_out_dbe4),
    .cnt_clr(cnt_clr), .sbe_count(sbe_count4), .dbe_count(dbe_count4)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: data bit i lives at the i-th non-power-of-two position.
  int dpos[DW];

  function automatic logic [CW-1:0] m_enc(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    logic          par;
    c = '0;
    for (int i = 0; i < DW; i++) c[dpos[i]] = d[i];
    for (int k = 0; k < 6; k++) begin
      par = 1'b0;
      for (int i = 0; i < DW; i++) if ((dpos[i] >> k) & 1) par ^= d[i];
      c[1 << k] = par;
    end
    c[0] = ^c;
    return c;
  endfunction

  function automatic logic [DW-1:0] m_ext(input logic [CW-1:0] c);
    logic [DW-1:0] d;
    for (int i = 0; i < DW; i++) d[i] = c[dpos[i]];
    return d;
  endfunction

  typedef struct { logic [DW-1:0] data; logic sbe; logic dbe; int cyc; } exp_t;
  typedef struct { logic [DW-1:0] data; logic [CW-1:0] mask; } stim_t;

  exp_t          exp_q[$];
  logic [CW-1:0] enc_q[$];
  stim_t         stim_q[$];

  int   cyc = 0;
  int   n_acc = 0;
  int   m_sbe = 0, m_dbe = 0, m_sbe4 = 0;
  logic acc_pend = 1'b0;
  logic chk_lat = 1'b0;
  logic rnd_ready = 1'b0;
  logic [CW-1:0] mon_c, mon_m;
  exp_t mon_e;
  int   nerr;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      acc_pend = enc_in_valid && enc_in_ready;
      if (acc_pend) begin
        mon_m = inj_en ? inj_mask : '0;
        mon_c = m_enc(enc_in_data) ^ mon_m;
        nerr  = $countones(mon_m);
        enc_q.push_back(mon_c);
        mon_e.data = (nerr >= 2) ? m_ext(mon_c) : enc_in_data;
        mon_e.sbe  = (nerr == 1);
        mon_e.dbe  = (nerr >= 2);
        mon_e.cyc  = cyc;
        exp_q.push_back(mon_e);
        n_acc++;
      end
      if (enc_out_valid && enc_out_ready) begin
        if (enc_q.size() == 0) chk("enc_unexpected", enc_out_valid, 1'b0);
        else chk("enc_cw", enc_out_cw, enc_q.pop_front());
      end
      chk("sbe_cnt", sbe_count, m_sbe);
      chk("dbe_cnt", dbe_count, m_dbe);
      chk("sbe_cnt4", sbe_count4, m_sbe4);
      if (dec_out_valid && dec_out_ready) begin
        if (exp_q.size() == 0) chk("dec_unexpected", dec_out_valid, 1'b0);
        else begin
          mon_e = exp_q.pop_front();
          chk("dec_data", dec_out_data, mon_e.data);
          chk("dec_sbe", dec_out_sbe, mon_e.sbe);
          chk("dec_dbe", dec_out_dbe, mon_e.dbe);
          if (chk_lat) chk("latency", cyc - mon_e.cyc, 3);
          if (!cnt_clr) begin
            if (mon_e.sbe && m_sbe < 65535) m_sbe++;
            if (mon_e.dbe && m_dbe < 65535) m_dbe++;
            if (mon_e.sbe && m_sbe4 < 15) m_sbe4++;
          end
        end
      end
      if (cnt_clr) begin
        m_sbe = 0; m_dbe = 0; m_sbe4 = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 2000; i++) begin
      if (stim_q.size() == 0 && !enc_in_valid && exp_q.size() == 0) break;
      step(1);
    end
    chk("drain_left", stim_q.size() + exp_q.size(), 0);
  endtask

  function automatic logic [CW-1:0] one_bit(input int b);
    logic [CW-1:0] m;
    m = '0;
    m[b] = 1'b1;
    return m;
  endfunction

  task automatic push(input logic [DW-1:0] d, input logic [CW-1:0] m);
    stim_t s;
    s.data = d;
    s.mask = m;
    stim_q.push_back(s);
  endtask

  initial begin
    int j;
    int a, b;
    int base;
    logic [31:0] words[4];
    j = 0;
    for (int pos = 1; pos < CW; pos++)
      if ((pos & (pos - 1)) != 0) begin
        dpos[j] = pos;
        j++;
      end
    words[0] = 32'hA5A5A5A5; words[1] = 32'hDEADBEEF;
    words[2] = 32'hFFFFFFFF; words[3] = 32'h12345678;
    enc_in_valid = 0; enc_in_data = '0; inj_en = 0; inj_mask = '0;
    cnt_clr = 0; dec_out_ready = 1;

    fork
      forever begin
        stim_t s;
        @(posedge clk);
        #1;
        if (rnd_ready) dec_out_ready = ($urandom_range(0, 3) != 0);
        if (acc_pend || !reset_n) enc_in_valid = 1'b0;
        if (!enc_in_valid && stim_q.size() > 0 && reset_n) begin
          s = stim_q.pop_front();
          enc_in_data  = s.data;
          inj_mask     = s.mask;
          inj_en       = (s.mask != '0);
          enc_in_valid = 1'b1;
        end
      end
    join_none

    step(3);
    chk("rst_enc_valid", enc_out_valid, 0);
    chk("rst_dec_valid", dec_out_valid, 0);
    chk("rst_enc_cw", enc_out_cw, 0);
    chk("rst_dec_flags", {dec_out_data, dec_out_sbe, dec_out_dbe}, 0);
    chk("rst_counts", {sbe_count, dbe_count}, 0);
    reset_n = 1;
    step(1);
    chk("rdy_enc", enc_in_ready, 1);
    chk("rdy_dec", dec_in_ready, 1);

    chk_lat = 1;
    push(32'h0, '0);
    drain();
    for (int i = 0; i < 4; i++) push(words[i], '0);
    drain();

    push(32'hA5A5A5A5, one_bit(5));
    drain();
    chk("sbe_after_bit5", sbe_count, 1);
    push(32'hA5A5A5A5, one_bit(0));
    drain();
    chk("sbe_after_bit0", sbe_count, 2);
    push(32'hCAFEBABE, one_bit(3) | one_bit(10));
    drain();
    chk("dbe_after_double", dbe_count, 1);
    chk("sbe_after_double", sbe_count, 2);
    chk_lat = 0;

    dec_out_ready = 0;
    push(32'h0BADF00D, one_bit(7) | one_bit(20));
    for (int i = 0; i < 50 && !dec_out_valid; i++) step(1);
    chk("wait_dbe_valid", dec_out_valid, 1);
    cnt_clr = 1;
    dec_out_ready = 1;
    step(1);
    cnt_clr = 0;
    chk("dbe_clr_wins", dbe_count, 0);
    drain();

    dec_out_ready = 0;
    base = n_acc;
    for (int i = 0; i < 5; i++) push($urandom, '0);
    step(8);
    chk("stall_accepted", n_acc - base, 3);
    chk("stall_enc_ready", enc_in_ready, 0);
    dec_out_ready = 1;
    drain();

    cnt_clr = 1;
    step(1);
    cnt_clr = 0;
    for (int i = 0; i < 20; i++) push($urandom, one_bit($urandom_range(0, CW - 1)));
    drain();
    chk("sat_cnt4", sbe_count4, 15);
    chk("sbe_cnt20", sbe_count, 20);

    rnd_ready = 1;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 2))
        0: push($urandom, '0);
        1: push($urandom, one_bit($urandom_range(0, CW - 1)));
        default: begin
          a = $urandom_range(0, CW - 1);
          b = (a + $urandom_range(1, CW - 1)) % CW;
          push($urandom, one_bit(a) | one_bit(b));
        end
      endcase
    end
    drain();
    step(1);
    rnd_ready = 0;
    dec_out_ready = 1;

    cnt_clr = 1;
    step(1);
    cnt_clr = 0;
    push(32'h11111111, one_bit(9));
    drain();
    dec_out_ready = 0;
    push(32'h22222222, '0);
    push(32'h33333333, '0);
    step(3);
    reset_n = 0;
    #1;
    chk("mid_rst_valids", {enc_out_valid, dec_out_valid}, 0);
    chk("mid_rst_counts", {sbe_count, dbe_count}, 0);
    chk("mid_rst_data", {enc_out_cw, dec_out_data}, 0);
    stim_q.delete();
    exp_q.delete();
    enc_q.delete();
    enc_in_valid = 0;
    inj_en = 0;
    acc_pend = 0;
    m_sbe = 0; m_dbe = 0; m_sbe4 = 0;
    step(2);
    reset_n = 1;
    dec_out_ready = 1;
    step(3);
    chk("post_rst_enc_valid", enc_out_valid, 0);
    chk("post_rst_dec_valid", dec_out_valid, 0);
    chk("post_rst_ready", enc_in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
